// File: rtl/sdram_arb_pkg.sv
// Shared types for the two-master SDRAM arbiter.
// Master ID, arbiter state enum and default read-pending depth.
package sdram_arb_pkg;

   typedef logic mid_t;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_st_t;

   localparam int MAX_PEND_DEF = 4;

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// Ordered FIFO of master IDs for reads still owed by the controller.
// Ports: clk_i/rst_ni, push_i+tag_i, pop_i, full_o, empty_o, head_o.
module sdram_arb_tag_fifo
   import sdram_arb_pkg::*;
#(
   parameter int DEPTH = MAX_PEND_DEF
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic push_i,
   input  mid_t tag_i,
   input  logic pop_i,
   output logic full_o,
   output logic empty_o,
   output mid_t head_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [PW-1:0] wp_q, wp_d;
   logic [PW-1:0] rp_q, rp_d;
   logic [CW-1:0] cnt_q, cnt_d;
   mid_t          mem_q [DEPTH];
   logic          do_push;
   logic          do_pop;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign head_o  = mem_q[rp_q];

   // A pop in the same cycle frees the slot, so a push is
   // taken even while full.
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_comb begin
      wp_d  = wp_q + PW'(do_push);
      rp_d  = rp_q + PW'(do_pop);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wp_q] <= tag_i;
   end

endmodule

// File: rtl/sdram_arb.sv
// Round-robin Avalon-MM arbiter: two masters onto one SDRAM slave.
// Ports: m0_*/m1_* master sides, s_* controller side, clk_clk, reset_reset_n.
module sdram_arb
   import sdram_arb_pkg::*;
#(
   parameter int ADDR_W   = 22,
   parameter int DATA_W   = 16,
   parameter int BE_W     = 2,
   parameter int MAX_PEND = MAX_PEND_DEF
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   input  logic [BE_W-1:0]   m0_byteenable,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   input  logic [BE_W-1:0]   m1_byteenable,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] s_address,
   output logic              s_read,
   output logic              s_write,
   output logic [DATA_W-1:0] s_writedata,
   output logic [BE_W-1:0]   s_byteenable,
   input  logic              s_waitrequest,
   input  logic [DATA_W-1:0] s_readdata,
   input  logic              s_readdatavalid
);

   logic    rst_done_q;
   arb_st_t st_q, st_d;
   mid_t    own_q, own_d;
   mid_t    last_q, last_d;

   logic    full, empty, push, pop;
   mid_t    head;
   logic    rd_ok, elig0, elig1;
   logic    sel_vld, fwd, accept;
   mid_t    sel_id;

   // Outputs stay at reset values until the first edge after release.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) rst_done_q <= 1'b0;
      else                rst_done_q <= 1'b1;
   end

   assign pop   = rst_done_q & s_readdatavalid & ~empty;
   assign rd_ok = ~full | pop;
   assign elig0 = m0_write | (m0_read & rd_ok);
   assign elig1 = m1_write | (m1_read & rd_ok);

   always_comb begin
      sel_vld = 1'b0;
      sel_id  = 1'b0;
      if (st_q == LOCKED) begin
         sel_id  = own_q;
         sel_vld = own_q ? (m1_read | m1_write)
                         : (m0_read | m0_write);
      end else begin
         unique case (1'b1)
            elig0 & elig1: begin
               sel_vld = 1'b1;
               sel_id  = ~last_q;
            end
            elig0 & ~elig1: begin
               sel_vld = 1'b1;
               sel_id  = 1'b0;
            end
            elig1 & ~elig0: begin
               sel_vld = 1'b1;
               sel_id  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign fwd     = rst_done_q & sel_vld;
   assign s_read  = fwd & (sel_id ? m1_read : m0_read);
   assign s_write = fwd & (sel_id ? m1_write : m0_write);

   always_comb begin
      s_address    = '0;
      s_writedata  = '0;
      s_byteenable = '0;
      if (rst_done_q) begin
         if (fwd & sel_id) begin
            s_address    = m1_address;
            s_writedata  = m1_writedata;
            s_byteenable = m1_byteenable;
         end else begin
            s_address    = m0_address;
            s_writedata  = m0_writedata;
            s_byteenable = m0_byteenable;
         end
      end
   end

   assign accept = (s_read | s_write) & ~s_waitrequest;
   assign push   = accept & s_read;

   assign m0_waitrequest = ~(accept & (sel_id == 1'b0));
   assign m1_waitrequest = ~(accept & (sel_id == 1'b1));

   assign m0_readdata = s_readdata;
   assign m1_readdata = s_readdata;
   assign m0_readdatavalid = pop & (head == 1'b0);
   assign m1_readdatavalid = pop & (head == 1'b1);

   always_comb begin
      st_d   = st_q;
      own_d  = own_q;
      last_d = last_q;
      if (accept) last_d = sel_id;
      unique case (st_q)
         IDLE: begin
            if (fwd & s_waitrequest) begin
               st_d  = LOCKED;
               own_d = sel_id;
            end
         end
         LOCKED: begin
            // Owner dropping its request is a protocol error;
            // release the lock rather than hang.
            if (accept | ~sel_vld) st_d = IDLE;
         end
         default: st_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         st_q   <= IDLE;
         own_q  <= 1'b0;
         last_q <= 1'b1;
      end else begin
         st_q   <= st_d;
         own_q  <= own_d;
         last_q <= last_d;
      end
   end

   sdram_arb_tag_fifo #(
      .DEPTH (MAX_PEND)
   ) u_tags (
      .clk_i   (clk_clk),
      .rst_ni  (reset_reset_n),
      .push_i  (push),
      .tag_i   (sel_id),
      .pop_i   (pop),
      .full_o  (full),
      .empty_o (empty),
      .head_o  (head)
   );

   a_owner_holds: assert property (
      @(posedge clk_clk) disable iff (!reset_reset_n || !rst_done_q)
      (st_q == LOCKED) |-> sel_vld);

   a_rdv_has_tag: assert property (
      @(posedge clk_clk) disable iff (!reset_reset_n || !rst_done_q)
      s_readdatavalid |-> !empty);

endmodule

// File: tb/tb_sdram_arb.sv
// Self-checking bench for sdram_arb: directed table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_sdram_arb;

   localparam int AW = 22;
   localparam int DW = 16;
   localparam int BW = 2;
   localparam int MP = 4;

   logic          clk_clk = 1'b0;
   logic          reset_reset_n;
   logic          r   [2];
   logic          w   [2];
   logic [AW-1:0] a   [2];
   logic [DW-1:0] wd  [2];
   logic [BW-1:0] be  [2];
   logic          s_waitrequest;
   logic [DW-1:0] s_readdata;
   logic          s_readdatavalid;

   logic          m0_waitrequest, m1_waitrequest;
   logic [DW-1:0] m0_readdata, m1_readdata;
   logic          m0_readdatavalid, m1_readdatavalid;
   logic [AW-1:0] s_address;
   logic          s_read, s_write;
   logic [DW-1:0] s_writedata;
   logic [BW-1:0] s_byteenable;

   always #5 clk_clk = ~clk_clk;

   sdram_arb #(
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .BE_W     (BW),
      .MAX_PEND (MP)
   ) dut (
      .clk_clk          (clk_clk),
      .reset_reset_n    (reset_reset_n),
      .m0_address       (a[0]),
      .m0_read          (r[0]),
      .m0_write         (w[0]),
      .m0_writedata     (wd[0]),
      .m0_byteenable    (be[0]),
      .m0_waitrequest   (m0_waitrequest),
      .m0_readdata      (m0_readdata),
      .m0_readdatavalid (m0_readdatavalid),
      .m1_address       (a[1]),
      .m1_read          (r[1]),
      .m1_write         (w[1]),
      .m1_writedata     (wd[1]),
      .m1_byteenable    (be[1]),
      .m1_waitrequest   (m1_waitrequest),
      .m1_readdata      (m1_readdata),
      .m1_readdatavalid (m1_readdatavalid),
      .s_address        (s_address),
      .s_read           (s_read),
      .s_write          (s_write),
      .s_writedata      (s_writedata),
      .s_byteenable     (s_byteenable),
      .s_waitrequest    (s_waitrequest),
      .s_readdata       (s_readdata),
      .s_readdatavalid  (s_readdatavalid)
   );

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask

   typedef struct {
      logic          r0, w0;
      logic [AW-1:0] a0;
      logic          r1, w1;
      logic [AW-1:0] a1;
      logic          sw, rdv;
      logic [DW-1:0] rd;
      logic          er, ew;
      logic [AW-1:0] ea;
      logic          ew0, ew1, ev0, ev1;
   } vec_t;

   function automatic vec_t mk(
      input logic r0, w0, input logic [AW-1:0] a0,
      input logic r1, w1, input logic [AW-1:0] a1,
      input logic sw, rdv, input logic [DW-1:0] rd,
      input logic er, ew, input logic [AW-1:0] ea,
      input logic ew0, ew1, ev0, ev1);
      vec_t v;
      v.r0 = r0; v.w0 = w0; v.a0 = a0;
      v.r1 = r1; v.w1 = w1; v.a1 = a1;
      v.sw = sw; v.rdv = rdv; v.rd = rd;
      v.er = er; v.ew = ew; v.ea = ea;
      v.ew0 = ew0; v.ew1 = ew1; v.ev0 = ev0; v.ev1 = ev1;
      return v;
   endfunction

   task automatic drv(input logic r0, w0, input logic [AW-1:0] a0,
                      input logic r1, w1, input logic [AW-1:0] a1,
                      input logic sw, rdv, input logic [DW-1:0] rd);
      r[0] = r0; w[0] = w0; a[0] = a0;
      r[1] = r1; w[1] = w1; a[1] = a1;
      s_waitrequest = sw; s_readdatavalid = rdv; s_readdata = rd;
   endtask

   task automatic next_cyc();
      @(posedge clk_clk);
      #1;
   endtask

   task automatic do_reset();
      reset_reset_n = 1'b0;
      drv(0, 0, '0, 0, 0, '0, 0, 0, '0);
      repeat (2) @(posedge clk_clk);
      #1 reset_reset_n = 1'b1;
      next_cyc();
   endtask

   vec_t tbl [15];

   // Reference model state
   int   tq [$];
   int   m_last;
   int   m_hold;

   initial begin
      tbl[0]  = mk(0,1,'h10, 0,1,'h20, 0,0,'h0,    0,1,'h10,  0,1,0,0);
      tbl[1]  = mk(0,1,'h10, 0,1,'h20, 0,0,'h0,    0,1,'h20,  1,0,0,0);
      tbl[2]  = mk(0,1,'h10, 0,1,'h20, 0,0,'h0,    0,1,'h10,  0,1,0,0);
      tbl[3]  = mk(0,1,'h10, 0,1,'h20, 0,0,'h0,    0,1,'h20,  1,0,0,0);
      tbl[4]  = mk(0,1,'h10, 0,0,'h20, 0,0,'h0,    0,1,'h10,  0,1,0,0);
      tbl[5]  = mk(0,1,'h10, 1,0,'h100,1,0,'h0,    1,0,'h100, 1,1,0,0);
      tbl[6]  = mk(0,1,'h10, 1,0,'h100,1,0,'h0,    1,0,'h100, 1,1,0,0);
      tbl[7]  = mk(0,1,'h10, 1,0,'h100,1,0,'h0,    1,0,'h100, 1,1,0,0);
      tbl[8]  = mk(0,1,'h10, 1,0,'h100,0,0,'h0,    1,0,'h100, 1,0,0,0);
      tbl[9]  = mk(0,1,'h10, 0,0,'h100,0,0,'h0,    0,1,'h10,  0,1,0,0);
      tbl[10] = mk(0,0,'h10, 0,0,'h20, 0,1,'hBEEF, 0,0,'h10,  1,1,0,1);
      tbl[11] = mk(1,0,'h10, 0,0,'h20, 0,0,'h0,    1,0,'h10,  0,1,0,0);
      tbl[12] = mk(0,0,'h10, 1,0,'h20, 0,0,'h0,    1,0,'h20,  1,0,0,0);
      tbl[13] = mk(0,0,'h10, 0,0,'h20, 0,1,'h1234, 0,0,'h10,  1,1,1,0);
      tbl[14] = mk(0,0,'h10, 0,0,'h20, 0,1,'hABCD, 0,0,'h10,  1,1,0,1);

      wd[0] = 16'h00A0; be[0] = 2'b01;
      wd[1] = 16'h00B1; be[1] = 2'b10;
      reset_reset_n = 1'b0;
      drv(0, 1, 'h10, 0, 1, 'h20, 0, 0, '0);
      #2;
      chk("rst_state",
          {s_read, s_write, s_address, s_writedata, s_byteenable,
           m0_waitrequest, m1_waitrequest,
           m0_readdatavalid, m1_readdatavalid},
          {1'b0, 1'b0, 22'h0, 16'h0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0});
      do_reset();

      // Directed table: round robin, lock, ordered returns
      for (int i = 0; i < 15; i++) begin
         drv(tbl[i].r0, tbl[i].w0, tbl[i].a0,
             tbl[i].r1, tbl[i].w1, tbl[i].a1,
             tbl[i].sw, tbl[i].rdv, tbl[i].rd);
         @(negedge clk_clk);
         chk($sformatf("tbl[%0d]", i),
             {s_read, s_write, s_address, m0_waitrequest,
              m1_waitrequest, m0_readdatavalid, m1_readdatavalid},
             {tbl[i].er, tbl[i].ew, tbl[i].ea, tbl[i].ew0,
              tbl[i].ew1, tbl[i].ev0, tbl[i].ev1});
         if (tbl[i].rdv)
            chk($sformatf("tbl_rdata[%0d]", i),
                {m0_readdata, m1_readdata}, {tbl[i].rd, tbl[i].rd});
         next_cyc();
      end

      // Fill with four m0 reads
      for (int i = 0; i < 4; i++) begin
         drv(1, 0, 'h40, 0, 0, 'h20, 0, 0, '0);
         @(negedge clk_clk);
         chk($sformatf("fill_rd[%0d]", i),
             {s_read, m0_waitrequest}, {1'b1, 1'b0});
         next_cyc();
      end
      drv(1, 0, 'h40, 0, 1, 'h20, 0, 0, '0);
      @(negedge clk_clk);
      chk("full_m1_write",
          {s_read, s_write, s_address, m0_waitrequest, m1_waitrequest},
          {1'b0, 1'b1, 22'h20, 1'b1, 1'b0});
      next_cyc();
      drv(1, 0, 'h40, 0, 0, 'h20, 0, 0, '0);
      @(negedge clk_clk);
      chk("full_rd_stall", {s_read, m0_waitrequest}, {1'b0, 1'b1});
      next_cyc();
      drv(1, 0, 'h40, 0, 0, 'h20, 0, 1, 16'h5555);
      @(negedge clk_clk);
      chk("full_pop_push",
          {s_read, m0_waitrequest, m0_readdatavalid, m0_readdata},
          {1'b1, 1'b0, 1'b1, 16'h5555});
      next_cyc();

      // Full, pop of m0 tag and m1 read in the same cycle
      drv(0, 0, 'h40, 1, 0, 'h60, 0, 1, 16'h6666);
      @(negedge clk_clk);
      chk("full_m1_swap",
          {s_read, s_address, m1_waitrequest,
           m0_readdatavalid, m1_readdatavalid},
          {1'b1, 22'h60, 1'b0, 1'b1, 1'b0});
      next_cyc();
      drv(1, 0, 'h40, 0, 0, 'h60, 0, 0, '0);
      @(negedge clk_clk);
      chk("still_full", {s_read, m0_waitrequest}, {1'b0, 1'b1});
      next_cyc();
      for (int i = 0; i < 4; i++) begin
         drv(0, 0, 'h40, 0, 0, 'h60, 0, 1, DW'(i));
         @(negedge clk_clk);
         chk($sformatf("drain[%0d]", i),
             {m0_readdatavalid, m1_readdatavalid},
             {(i < 3) ? 1'b1 : 1'b0, (i == 3) ? 1'b1 : 1'b0});
         next_cyc();
      end

      // Reset with two reads outstanding
      drv(1, 0, 'h40, 0, 0, 'h20, 0, 0, '0);
      next_cyc();
      drv(0, 0, 'h40, 1, 0, 'h20, 0, 0, '0);
      next_cyc();
      drv(0, 1, 'h44, 0, 1, 'h24, 0, 1, 16'h7777);
      #1 reset_reset_n = 1'b0;
      #1;
      chk("rst_async",
          {s_read, s_write, s_address, s_writedata, s_byteenable,
           m0_waitrequest, m1_waitrequest,
           m0_readdatavalid, m1_readdatavalid},
          {1'b0, 1'b0, 22'h0, 16'h0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0});
      repeat (2) @(posedge clk_clk);
      #1 reset_reset_n = 1'b1;
      @(negedge clk_clk);
      chk("rst_late_rdv",
          {s_write, m0_readdatavalid, m1_readdatavalid},
          {1'b0, 1'b0, 1'b0});
      #1 s_readdatavalid = 1'b0;
      next_cyc();
      @(negedge clk_clk);
      chk("rst_m0_first",
          {s_write, s_address, m0_waitrequest, m1_waitrequest,
           m0_readdatavalid, m1_readdatavalid},
          {1'b1, 22'h44, 1'b0, 1'b1, 1'b0, 1'b0});
      next_cyc();

      // Randomized traffic against the reference model
      do_reset();
      tq.delete();
      m_last = 1;
      m_hold = -1;
      for (int c = 0; c < 3000; c++) begin
         logic          pop, room, sw;
         logic          e [2];
         int            sel;
         logic          xr, xw;
         logic [AW-1:0] xa;
         logic [DW-1:0] xwd;
         logic [BW-1:0] xbe;
         logic          xv0, xv1;

         for (int n = 0; n < 2; n++) begin
            if (m_hold != n) begin
               int k;
               k = $urandom_range(0, 4);
               r[n]  = (k == 1) || (k == 3);
               w[n]  = (k == 2);
               a[n]  = AW'($urandom_range(0, 1023));
               wd[n] = DW'($urandom);
               be[n] = BW'($urandom_range(0, 3));
            end
         end
         sw = ($urandom_range(0, 3) == 0);
         s_waitrequest   = sw;
         s_readdatavalid = (tq.size() > 0) && ($urandom_range(0, 2) == 0);
         s_readdata      = DW'($urandom);

         pop  = s_readdatavalid;
         room = (tq.size() < MP) || pop;
         for (int n = 0; n < 2; n++) e[n] = w[n] || (r[n] && room);
         if (m_hold >= 0)
            sel = (r[m_hold] || w[m_hold]) ? m_hold : -1;
         else if (e[0] && e[1]) sel = 1 - m_last;
         else if (e[0])         sel = 0;
         else if (e[1])         sel = 1;
         else                   sel = -1;

         xr  = (sel >= 0) && r[(sel == 1) ? 1 : 0];
         xw  = (sel >= 0) && w[(sel == 1) ? 1 : 0];
         xa  = (sel == 1) ? a[1]  : a[0];
         xwd = (sel == 1) ? wd[1] : wd[0];
         xbe = (sel == 1) ? be[1] : be[0];
         xv0 = pop && (tq[0] == 0);
         xv1 = pop && (tq[0] == 1);

         @(negedge clk_clk);
         chk($sformatf("rand[%0d]", c),
             {s_read, s_write, s_address, s_writedata, s_byteenable,
              m0_waitrequest, m1_waitrequest,
              m0_readdatavalid, m1_readdatavalid,
              m0_readdata, m1_readdata},
             {xr, xw, xa, xwd, xbe,
              !(sel == 0 && !sw), !(sel == 1 && !sw),
              xv0, xv1, s_readdata, s_readdata});

         if (pop) void'(tq.pop_front());
         if (sel >= 0 && !sw) begin
            m_last = sel;
            if (xr) tq.push_back(sel);
            m_hold = -1;
         end else if (sel >= 0) begin
            m_hold = sel;
         end else begin
            m_hold = -1;
         end
         next_cyc();
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
